if_id_buffer: RTL

Pipeline boundary between instruction fetch and decode in the 5-stage MIPS core. Registers the fetch stage's `{ce, pc}` bus and pairs it with the matching instruction word from the synchronous instruction SRAM, which returns data one cycle after the address edge. Holds the pair stable across stalls by saving the SRAM word on the first held cycle, because the SRAM is re-read while the PC is frozen. Inserts bubbles and honours flushes, so decode always sees a coherent `{valid, pc, inst}` triple.

---
 rtl/if_id_buffer_pkg.sv | 24 ++
 rtl/if_id_buffer_if.sv | 24 ++
 rtl/if_id_buffer_inst_hold_buf.sv | 40 ++++
 rtl/if_id_buffer.sv | 69 ++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared widths, stall encoding and state constants for the IF/ID boundary.
package if_id_buffer_pkg;

  localparam int STALL_W      = 6;   // one hold bit per pipeline stage
  localparam int STG_IF       = 1;   // fetch stage bit in the stall bus
  localparam int STG_ID       = 2;   // decode stage bit in the stall bus
  localparam int IF_TO_ID_WD  = 33;  // {ce, pc}
  localparam int IF_ID_BUS_WD = 65;  // {valid, pc, inst}

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Instruction-save state: word taken live from SRAM, or from the saved copy
  localparam logic [0:0] LIVE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  typedef logic [STALL_W-1:0] stall_bus_t;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// Bus bundle between fetch/controller (master) and the IF/ID boundary (slave).
interface if_id_buffer_if;
  import if_id_buffer_pkg::*;

  stall_bus_t                stall;
  logic                      flush;
  logic [IF_TO_ID_WD-1:0]    if_to_id_bus;
  logic [31:0]               inst_sram_rdata;
  logic                      id_valid;
  logic [31:0]               id_pc;
  logic [31:0]               id_inst;
  logic [IF_ID_BUS_WD-1:0]   id_bus;

  modport master (
    output stall, flush, if_to_id_bus, inst_sram_rdata,
    input  id_valid, id_pc, id_inst, id_bus
  );

  modport slave (
    input  stall, flush, if_to_id_bus, inst_sram_rdata,
    output id_valid, id_pc, id_inst, id_bus
  );

endinterface

// File: rtl/if_id_buffer_inst_hold_buf.sv
// Saves the SRAM word on the first held edge so decode keeps a stable
// instruction while the SRAM is re-read with a frozen PC.
module inst_hold_buf
  import if_id_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        hold,
  input  logic [31:0] rdata,
  output logic        held,
  output logic [31:0] inst
);

  logic [0:0]  r_held;
  logic [31:0] r_inst;

  // LIVE->HELD captures the word once; HELD->LIVE on release or clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held <= LIVE;
      r_inst <= '0;
    end else if (clr) begin
      r_held <= LIVE;
    end else begin
      case (r_held)
        LIVE: if (hold) begin
          r_held <= HELD;
          r_inst <= rdata;
        end
        HELD: if (!hold) r_held <= LIVE;
        default: r_held <= LIVE;
      endcase
    end
  end

  assign held = r_held[0];
  assign inst = r_inst;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline boundary: registers {ce, pc} and pairs it with the
// one-cycle-late SRAM word, holding the pair coherent across stalls.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter logic [31:0] PC_RST   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  if_id_buffer_if.slave        bus
);

  logic        r_valid;
  logic [31:0] r_pc;
  if_to_id_t   w_fetch;
  logic        w_if_stop;
  logic        w_id_stop;
  logic        w_hold;
  logic        w_held;
  logic [31:0] w_buf_inst;
  logic [31:0] w_inst;
  logic        w_unused_stall;

  assign w_fetch   = if_to_id_t'(bus.if_to_id_bus);
  assign w_if_stop = (bus.stall[STG_IF] == Stop);
  assign w_id_stop = (bus.stall[STG_ID] == Stop);
  assign w_unused_stall = ^{bus.stall[STALL_W-1:STG_ID+1], bus.stall[0]};

  // Stay held for the whole decode stall once entered, even if valid drops
  assign w_hold = w_id_stop && (r_valid || w_held);

  // Entry register: clear, bubble, advance, or hold, in that priority
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_valid <= 1'b0;
      r_pc    <= PC_RST;
    end else if (w_if_stop && !w_id_stop) begin
      r_valid <= 1'b0;
      r_pc    <= PC_RST;
    end else if (!w_if_stop) begin
      r_valid <= w_fetch.ce;
      r_pc    <= w_fetch.pc;
    end
  end

  inst_hold_buf u_hold (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.flush),
    .hold  (w_hold),
    .rdata (bus.inst_sram_rdata),
    .held  (w_held),
    .inst  (w_buf_inst)
  );

  // Instruction select: NOP for bubbles, saved word while held, else live SRAM
  always_comb begin
    w_inst = bus.inst_sram_rdata;
    if (!r_valid)    w_inst = NOP_INST;
    else if (w_held) w_inst = w_buf_inst;
  end

  assign bus.id_valid = r_valid;
  assign bus.id_pc    = r_pc;
  assign bus.id_inst  = w_inst;
  assign bus.id_bus   = {r_valid, r_pc, w_inst};

endmodule
